// File: rtl/bp_sacc_spm_arbiter.sv
// bp_sacc_spm_arbiter
//   Shares the accelerator's single-port scratchpad (1-cycle synchronous read)
//   between the IO command path (port 0) and the accel engine (port 1).
//   Round-robin grant, one outstanding access per port, per-port response
//   register with valid/yumi handshake, per-port accepted-write counters.
//
// Ports
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   req_v_i      per-port request valid
//   req_w_i      per-port write (1) / read (0)
//   req_addr_i   per-port word address, port i at [i*aw +: aw]
//   req_data_i   per-port write data, port i at [i*dw +: dw]
//   req_ready_o  per-port accept (request taken when req_v_i & req_ready_o)
//   resp_v_o     per-port response valid
//   resp_data_o  per-port read data ('0 for writes and out-of-range reads)
//   resp_yumi_i  per-port response consume
//   spm_v_o      SPM enable
//   spm_w_o      SPM write enable
//   spm_addr_o   SPM address
//   spm_data_o   SPM write data
//   spm_data_i   SPM read data, valid the cycle after a read enable
//   wr_cnt_o     per-port accepted-write count, port i at [i*cw +: cw]
module bp_sacc_spm_arbiter #(
  parameter int unsigned data_width_p = 64,
  parameter int unsigned els_p        = 20,
  parameter int unsigned cnt_width_p  = 64,
  localparam int unsigned addr_width_lp = (els_p <= 1) ? 1 : $clog2(els_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [1:0]                  req_v_i,
  input  logic [1:0]                  req_w_i,
  input  logic [2*addr_width_lp-1:0]  req_addr_i,
  input  logic [2*data_width_p-1:0]   req_data_i,
  output logic [1:0]                  req_ready_o,
  output logic [1:0]                  resp_v_o,
  output logic [2*data_width_p-1:0]   resp_data_o,
  input  logic [1:0]                  resp_yumi_i,
  output logic                        spm_v_o,
  output logic                        spm_w_o,
  output logic [addr_width_lp-1:0]    spm_addr_o,
  output logic [data_width_p-1:0]     spm_data_o,
  input  logic [data_width_p-1:0]     spm_data_i,
  output logic [2*cnt_width_p-1:0]    wr_cnt_o
);

  // Depth widened by one bit so an exact power-of-two depth still compares correctly.
  localparam logic [addr_width_lp:0] els_lp = (addr_width_lp+1)'(els_p);

  logic [1:0]                    pend_r;
  logic [1:0]                    pend_w_r;
  logic [1:0]                    pend_oor_r;
  logic [1:0]                    resp_v_r;
  logic [1:0][data_width_p-1:0]  resp_data_r;
  logic [cnt_width_p-1:0]        wr_cnt0_r;
  logic [cnt_width_p-1:0]        wr_cnt1_r;
  logic                          last_r;

  logic [1:0]                    elig;
  logic [1:0]                    grant;
  logic                          gnt_v;
  logic                          gnt_idx;
  logic                          sel_w;
  logic                          sel_oor;
  logic [addr_width_lp-1:0]      sel_addr;
  logic [data_width_p-1:0]       sel_data;

  // A port may be granted only if it has no access in flight and its response
  // slot is empty or being drained this cycle. Gating with reset_n_i keeps the
  // handshake and SPM quiet while reset is held.
  always_comb begin
    elig     = req_v_i & ~pend_r & (~resp_v_r | resp_yumi_i);
    gnt_v    = reset_n_i & (|elig);
    gnt_idx  = (elig == 2'b11) ? ~last_r : elig[1];
    grant    = '0;
    if (gnt_v) grant[gnt_idx] = 1'b1;
    sel_w    = req_w_i[gnt_idx];
    sel_addr = req_addr_i[gnt_idx*addr_width_lp +: addr_width_lp];
    sel_data = req_data_i[gnt_idx*data_width_p +: data_width_p];
    sel_oor  = ({1'b0, sel_addr} >= els_lp);
  end

  assign req_ready_o = grant;
  assign spm_v_o     = gnt_v & ~sel_oor;
  assign spm_w_o     = gnt_v & sel_w;
  assign spm_addr_o  = sel_addr;
  assign spm_data_o  = sel_data;
  assign resp_v_o    = resp_v_r;
  assign resp_data_o = resp_data_r;
  assign wr_cnt_o    = {wr_cnt1_r, wr_cnt0_r};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pend_r      <= '0;
      pend_w_r    <= '0;
      pend_oor_r  <= '0;
      resp_v_r    <= '0;
      resp_data_r <= '0;
      wr_cnt0_r   <= '0;
      wr_cnt1_r   <= '0;
      last_r      <= 1'b1;
    end else begin
      // Each grant is pending for exactly one cycle: the cycle SPM read data arrives.
      pend_r <= grant;
      if (gnt_v) begin
        last_r              <= gnt_idx;
        pend_w_r[gnt_idx]   <= sel_w;
        pend_oor_r[gnt_idx] <= sel_oor;
      end
      for (int unsigned i = 0; i < 2; i++) begin
        // A completing access refills the slot even if it is consumed in the same edge.
        if (pend_r[i]) begin
          resp_v_r[i]    <= 1'b1;
          resp_data_r[i] <= (~pend_w_r[i] & ~pend_oor_r[i]) ? spm_data_i : '0;
        end else if (resp_yumi_i[i]) begin
          resp_v_r[i]    <= 1'b0;
        end
      end
      if (grant[0] & req_w_i[0]) wr_cnt0_r <= wr_cnt0_r + 1'b1;
      if (grant[1] & req_w_i[1]) wr_cnt1_r <= wr_cnt1_r + 1'b1;
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ((resp_yumi_i & ~resp_v_r) == 2'b00));

endmodule

// File: tb/tb_bp_sacc_spm_arbiter.sv
module tb_bp_sacc_spm_arbiter;
  localparam int DW  = 64;
  localparam int ELS = 20;
  localparam int CW  = 64;
  localparam int AW  = 5;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [1:0]        req_v_i, req_w_i, req_ready_o, resp_v_o, resp_yumi_i;
  logic [2*AW-1:0]   req_addr_i;
  logic [2*DW-1:0]   req_data_i, resp_data_o;
  logic              spm_v_o, spm_w_o;
  logic [AW-1:0]     spm_addr_o;
  logic [DW-1:0]     spm_data_o, spm_data_i;
  logic [2*CW-1:0]   wr_cnt_o;

  always #5 clk_i = ~clk_i;

  bp_sacc_spm_arbiter #(.data_width_p(DW), .els_p(ELS), .cnt_width_p(CW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_w_i(req_w_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
    .resp_yumi_i(resp_yumi_i), .spm_v_o(spm_v_o), .spm_w_o(spm_w_o),
    .spm_addr_o(spm_addr_o), .spm_data_o(spm_data_o), .spm_data_i(spm_data_i),
    .wr_cnt_o(wr_cnt_o));

  // Scratchpad: synchronous 1-cycle read; read data is garbage when not reading.
  logic [DW-1:0] mem [32];
  always @(posedge clk_i) begin
    if (spm_v_o && spm_w_o) mem[spm_addr_o] <= spm_data_o;
    if (spm_v_o && !spm_w_o) spm_data_i <= mem[spm_addr_o];
    else                     spm_data_i <= {$urandom, $urandom};
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each port holds at most one transaction from accept until
  // its response is consumed; the response becomes visible two cycles after accept.
  bit          out_v [2];
  int          out_t [2];
  logic [63:0] out_d [2];
  logic [63:0] cnt   [2];
  logic [63:0] gold  [ELS];
  bit          last;
  int          cyc = 0;
  int          hs [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin out_v[i] = 0; cnt[i] = '0; end
    last = 1;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic [1:0] v, input logic [1:0] w,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [63:0] d0, input logic [63:0] d1,
                      input logic [1:0] yumi_want);
    bit vis [2];
    bit el  [2];
    int g;
    logic [AW-1:0] a [2];
    logic [63:0]   d [2];
    logic [1:0]    exp_ready, exp_vis;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    for (int i = 0; i < 2; i++) begin
      vis[i] = out_v[i] && (cyc >= out_t[i] + 2);
      exp_vis[i] = vis[i];
    end
    req_v_i     = v;
    req_w_i     = w;
    req_addr_i  = {a1, a0};
    req_data_i  = {d1, d0};
    resp_yumi_i = yumi_want & exp_vis;
    #1;
    for (int i = 0; i < 2; i++) el[i] = v[i] && (!out_v[i] || (vis[i] && resp_yumi_i[i]));
    if (el[0] && el[1]) g = last ? 0 : 1;
    else if (el[0])     g = 0;
    else if (el[1])     g = 1;
    else                g = -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_eq("req_ready", req_ready_o, exp_ready);
    check_eq("spm_v", spm_v_o, (g >= 0) && (a[g] < ELS));
    if (g >= 0) begin
      check_eq("spm_w", spm_w_o, w[g]);
      if (a[g] < ELS) check_eq("spm_addr", spm_addr_o, a[g]);
      if (a[g] < ELS && w[g]) check_eq("spm_data", spm_data_o, d[g]);
    end else begin
      check_eq("spm_w_idle", spm_w_o, 1'b0);
    end
    check_eq("resp_v", resp_v_o, exp_vis);
    for (int i = 0; i < 2; i++) begin
      if (vis[i]) check_eq($sformatf("resp_data%0d", i), resp_data_o[i*DW +: DW], out_d[i]);
      if (resp_v_o[i] && resp_yumi_i[i]) hs[i]++;
    end
    check_eq("wr_cnt", wr_cnt_o, {cnt[1], cnt[0]});
    // commit model state for this clock edge
    for (int i = 0; i < 2; i++) if (vis[i] && resp_yumi_i[i]) out_v[i] = 0;
    if (g >= 0) begin
      out_v[g] = 1;
      out_t[g] = cyc;
      out_d[g] = (!w[g] && a[g] < ELS) ? gold[a[g]] : '0;
      if (w[g] && a[g] < ELS) gold[a[g]] = d[g];
      if (w[g]) cnt[g] = cnt[g] + 1;
      last = (g == 1);
    end
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input logic [1:0] yumi);
    for (int k = 0; k < n; k++) step(2'b00, 2'b00, '0, '0, '0, '0, yumi);
  endtask

  // Called at a negedge; holds reset for two edges with requests asserted.
  task automatic do_reset();
    reset_n_i   = 1'b0;
    req_v_i     = 2'b11;
    req_w_i     = 2'b11;
    resp_yumi_i = 2'b00;
    #1;
    model_reset();
    check_eq("rst_ready", req_ready_o, 2'b00);
    check_eq("rst_spm_v", spm_v_o, 1'b0);
    check_eq("rst_resp_v", resp_v_o, 2'b00);
    check_eq("rst_wr_cnt", wr_cnt_o, '0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    req_v_i   = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < ELS; i++) gold[i] = '0;
    hs[0] = 0; hs[1] = 0;
    reset_n_i = 1'b0; req_v_i = '0; req_w_i = '0; req_addr_i = '0;
    req_data_i = '0; resp_yumi_i = '0;
    model_reset();
    @(negedge clk_i);
    do_reset();

    // Both ports read every cycle: alternation starting at port 0, SPM always busy.
    hs[0] = 0; hs[1] = 0;
    for (int k = 0; k < 20; k++)
      step(2'b11, 2'b00, AW'(k % ELS), AW'((k + 7) % ELS), '0, '0, 2'b11);
    idle(4, 2'b11);
    check_eq("alt_resp_cnt0", hs[0], 10);
    check_eq("alt_resp_cnt1", hs[1], 10);

    // Port 0 write then read back address 3.
    step(2'b01, 2'b01, 5'd3, '0, 64'hDEAD_BEEF, '0, 2'b00);
    idle(3, 2'b11);
    step(2'b01, 2'b00, 5'd3, '0, '0, '0, 2'b00);
    idle(3, 2'b11);

    // Port 1 read with response held unconsumed, then consumed alongside a new request.
    step(2'b10, 2'b00, '0, 5'd3, '0, '0, 2'b00);
    for (int k = 0; k < 6; k++) step(2'b10, 2'b00, '0, 5'd4, '0, '0, 2'b00);
    step(2'b10, 2'b00, '0, 5'd4, '0, '0, 2'b10);
    idle(3, 2'b11);

    // Out-of-range write on port 0.
    step(2'b01, 2'b01, 5'd25, '0, 64'h1234_5678_9ABC_DEF0, '0, 2'b00);
    idle(3, 2'b11);

    // Reset in the cycle after a read grant: access dropped, port 0 wins the next tie.
    step(2'b01, 2'b00, 5'd3, '0, '0, '0, 2'b00);
    do_reset();
    step(2'b11, 2'b00, 5'd3, 5'd5, '0, '0, 2'b00);
    idle(4, 2'b11);

    // Port 1 write counter wrap.
    force dut.wr_cnt1_r = '1;
    #1;
    release dut.wr_cnt1_r;
    cnt[1] = '1;
    step(2'b10, 2'b10, '0, 5'd7, '0, 64'h1, 2'b00);
    idle(2, 2'b11);
    step(2'b10, 2'b10, '0, 5'd8, '0, 64'h2, 2'b00);
    idle(3, 2'b11);

    // Randomized traffic including out-of-range addresses and yumi backpressure.
    for (int k = 0; k < 800; k++)
      step(2'($urandom), 2'($urandom), AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
           {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom));
    idle(4, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
